// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider.
// Holds the FSM state encoding, default operand widths and the iteration count.
package div_pkg;

  localparam int unsigned N_DIVIDENDO_DEF = 16;
  localparam int unsigned N_DIVISOR_DEF   = 8;

  // One quotient bit per CALC cycle; the counter runs ITER_COUNT down to 0.
  localparam int unsigned ITER_COUNT = 16;
  localparam int unsigned CNT_W      = 5;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFin
  } estado_t;

endpackage

// File: rtl/magnitud.sv
// Combinational two's-complement absolute value.
// Ports:
//   valor : signed input operand (W bits)
//   mag   : unsigned magnitude (W bits); the most negative value maps to 2^(W-1)
module magnitud #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] valor,
  output logic [W-1:0] mag
);

  always_comb begin
    mag = valor;
    if (valor[W-1]) begin
      mag = ~valor + W'(1);
    end
  end

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential signed divider: restoring shift-subtract on operand magnitudes, one quotient
// bit per clock, with sign restore, divide-by-zero and overflow handling at the end.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : level request; only a rising edge seen in IDLE starts an operation
//   A, B            : signed dividend / divisor
//   q, r            : signed quotient (toward zero) / remainder (sign of dividend)
//   neg             : quotient is negative and non-zero
//   busy, done      : operation in progress / one-cycle result-valid pulse
//   div_zero, ovf   : B was zero / quotient saturated (A = min, B = -1)
module divisor_secuencial
  import div_pkg::*;
#(
  parameter int unsigned N_DIVIDENDO = N_DIVIDENDO_DEF,
  parameter int unsigned N_DIVISOR   = N_DIVISOR_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_DIVIDENDO-1:0] A,
  input  logic [N_DIVISOR-1:0]   B,
  output logic [N_DIVIDENDO-1:0] q,
  output logic [N_DIVISOR-1:0]   r,
  output logic                   neg,
  output logic                   busy,
  output logic                   done,
  output logic                   div_zero,
  output logic                   ovf
);

  estado_t state_q, state_d;

  logic                   start_prev_q;
  logic                   a_sign_q, b_sign_q;
  logic                   zero_q, sat_q;
  logic [N_DIVIDENDO-1:0] quo_q;
  logic [N_DIVISOR-1:0]   rem_q;
  logic [N_DIVISOR-1:0]   b_mag_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [N_DIVIDENDO-1:0] q_q;
  logic [N_DIVISOR-1:0]   r_q;
  logic                   neg_q, done_q, div_zero_q, ovf_q;

  logic [N_DIVIDENDO-1:0] a_mag;
  logic [N_DIVISOR-1:0]   b_mag;

  magnitud #(.W(N_DIVIDENDO)) u_mag_a (.valor(A), .mag(a_mag));
  magnitud #(.W(N_DIVISOR))   u_mag_b (.valor(B), .mag(b_mag));

  logic start_rise, b_is_zero, sat_case;
  assign start_rise = start & ~start_prev_q;
  assign b_is_zero  = (B == '0);
  assign sat_case   = (A == {1'b1, {(N_DIVIDENDO - 1){1'b0}}}) && (B == '1);

  // Partial remainder is one bit wider than the divisor so |B| = 2^(N_DIVISOR-1) works.
  logic [N_DIVISOR:0]   shifted;
  logic                 ge;
  logic [N_DIVISOR-1:0] sub;
  assign shifted = {rem_q, quo_q[N_DIVIDENDO-1]};
  assign ge      = (shifted >= {1'b0, b_mag_q});
  // When ge holds the true difference is below |B|, so the narrow subtraction is exact.
  assign sub     = shifted[N_DIVISOR-1:0] - b_mag_q;

  // Final signed results computed from the magnitudes
  logic                   sign_diff;
  logic [N_DIVIDENDO-1:0] q_fin;
  logic [N_DIVISOR-1:0]   r_fin;
  logic                   neg_fin;

  always_comb begin
    sign_diff = a_sign_q ^ b_sign_q;
    q_fin     = sign_diff ? (~quo_q + N_DIVIDENDO'(1)) : quo_q;
    r_fin     = a_sign_q ? (~rem_q + N_DIVISOR'(1)) : rem_q;
    neg_fin   = sign_diff && (quo_q != '0);
    if (zero_q) begin
      q_fin   = '1;
      r_fin   = '0;
      neg_fin = 1'b0;
    end else if (sat_q) begin
      q_fin   = {1'b0, {(N_DIVIDENDO - 1){1'b1}}};
      r_fin   = '0;
      neg_fin = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_rise) state_d = b_is_zero ? StFin : StCalc;
      StCalc: if (cnt_q == CNT_W'(1)) state_d = StFin;
      StFin:  if (cnt_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      start_prev_q <= 1'b1;  // a start already high at reset release is not an edge
      a_sign_q     <= 1'b0;
      b_sign_q     <= 1'b0;
      zero_q       <= 1'b0;
      sat_q        <= 1'b0;
      quo_q        <= '0;
      rem_q        <= '0;
      b_mag_q      <= '0;
      cnt_q        <= '0;
      q_q          <= '0;
      r_q          <= '0;
      neg_q        <= 1'b0;
      done_q       <= 1'b0;
      div_zero_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      done_q       <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_rise) begin
            a_sign_q   <= A[N_DIVIDENDO-1];
            b_sign_q   <= B[N_DIVISOR-1];
            zero_q     <= b_is_zero;
            sat_q      <= sat_case;
            quo_q      <= a_mag;
            rem_q      <= '0;
            b_mag_q    <= b_mag;
            // Divide-by-zero spends one settle cycle in FIN so done lands two edges later.
            cnt_q      <= b_is_zero ? CNT_W'(1) : CNT_W'(ITER_COUNT);
            q_q        <= '0;
            r_q        <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
          end
        end
        StCalc: begin
          rem_q <= ge ? sub : shifted[N_DIVISOR-1:0];
          quo_q <= {quo_q[N_DIVIDENDO-2:0], ge};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        StFin: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            q_q        <= q_fin;
            r_q        <= r_fin;
            neg_q      <= neg_fin;
            div_zero_q <= zero_q;
            ovf_q      <= sat_q && !zero_q;
            done_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign q        = q_q;
  assign r        = r_q;
  assign neg      = neg_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_divisor_secuencial.sv
module tb_divisor_secuencial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [7:0]  B;
  logic [15:0] q;
  logic [7:0]  r;
  logic        neg, busy, done, div_zero, ovf;

  divisor_secuencial dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .q(q), .r(r), .neg(neg), .busy(busy), .done(done),
    .div_zero(div_zero), .ovf(ovf)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [15:0] q;
    logic [7:0]  r;
    logic        neg;
    logic        dz;
    logic        ovf;
    int          k;    // edge number at which start is sampled
    int          lat;  // edges from k until done is visible
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops an expectation on every done pulse
  initial begin
    exp_t e;
    logic prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done && prev_done) check("done_one_cycle", 32'(prev_done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check({e.name, "_q"}, 32'(q), 32'(e.q));
          check({e.name, "_r"}, 32'(r), 32'(e.r));
          check({e.name, "_flags"}, {29'd0, neg, div_zero, ovf}, {29'd0, e.neg, e.dz, e.ovf});
          check({e.name, "_latency"}, 32'(cyc - e.k), 32'(e.lat));
          check({e.name, "_busy_low"}, 32'(busy), 32'd0);
        end
      end
      prev_done = done;
    end
  end

  task automatic issue(input string name, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input logic en,
                       input logic edz, input logic eovf, input int lat);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    e.name = name; e.q = eq; e.r = er; e.neg = en; e.dz = edz; e.ovf = eovf;
    e.k = cyc + 1; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int waited = 0;
    while (busy && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_finished"}, 32'(busy), 32'd0);
  endtask

  task automatic do_op(input string name, input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic [7:0] er, input logic en,
                       input logic edz, input logic eovf, input int lat);
    issue(name, a, b, eq, er, en, edz, eovf, lat);
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_after_start"}, 32'(busy), 32'd1);
    check({name, "_cleared_at_start"}, {15'd0, q, div_zero}, 32'd0);
    wait_idle(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; A = 16'd0; B = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {3'd0, q, r, neg, busy, done, div_zero, ovf}, 32'd0);
    rst = 1'b0;
    // start still high after reset: not an edge
    repeat (4) @(negedge clk);
    check("no_start_after_reset", {31'd0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clk);

    do_op("pos_negB", 16'd100,    -8'sd7,   16'hFFF2, 8'h02, 1'b1, 1'b0, 1'b0, 17);
    do_op("negA_pos", -16'sd100,  8'd7,     16'hFFF2, 8'hFE, 1'b1, 1'b0, 1'b0, 17);
    do_op("negA_exact", -16'sd9,  8'd3,     16'hFFFD, 8'h00, 1'b1, 1'b0, 1'b0, 17);
    do_op("div_zero", 16'd5,      8'd0,     16'hFFFF, 8'h00, 1'b0, 1'b1, 1'b0, 2);
    do_op("ovf", 16'h8000,        8'hFF,    16'h7FFF, 8'h00, 1'b0, 1'b0, 1'b1, 17);
    repeat (5) @(negedge clk);
    check("ovf_hold", {15'd0, q, ovf}, {15'd0, 16'h7FFF, 1'b1});
    do_op("min_by_m128", 16'h8000, 8'h80,   16'h0100, 8'h00, 1'b0, 1'b0, 1'b0, 17);
    do_op("max_by_127", 16'h7FFF, 8'h7F,    16'h0102, 8'h01, 1'b0, 1'b0, 1'b0, 17);
    do_op("zero_quo_negB", 16'd7, -8'sd9,   16'h0000, 8'h07, 1'b0, 1'b0, 1'b0, 17);
    do_op("zero_quo_negA", -16'sd7, 8'd9,   16'h0000, 8'hF9, 1'b0, 1'b0, 1'b0, 17);

    // start held high 300 ns with an extra edge while busy: one result only
    issue("held_start", 16'd1000, 8'd7, 16'h008E, 8'h06, 1'b0, 1'b0, 1'b0, 17);
    repeat (15) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (25) @(negedge clk);
    check("held_start_idle", {31'd0, busy}, 32'd0);
    start = 1'b0;
    @(negedge clk);

    // reset in the middle of CALC aborts the operation
    @(negedge clk);
    A = 16'd50; B = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #5 rst = 1'b1;
    #30 rst = 1'b0;
    @(negedge clk);
    check("mid_calc_reset", {3'd0, q, r, neg, busy, done, div_zero, ovf}, 32'd0);
    do_op("after_reset", 16'd9, -8'sd3, 16'hFFFD, 8'h00, 1'b1, 1'b0, 1'b0, 17);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 SHALL have parameter N_DIVIDENDO, default 16: dividend and quotient width.
REQ-002 SHALL have parameter N_DIVISOR, default 8: divisor and remainder width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 start  input  1  request a new division; level signal, rising edge acted on.
REQ-006 A  input  16  dividend, signed two's complement.
REQ-007 B  input  8  divisor, signed two's complement.
REQ-008 q  output  16  quotient, signed two's complement, truncated toward zero.
REQ-009 r  output  8  remainder, signed; sign follows dividend.
REQ-010 neg  output  1  quotient sign flag: 1 when signs of A and B differ and q != 0.
REQ-011 busy  output  1  high while a division is in progress.
REQ-012 done  output  1  one-cycle pulse when q/r/flags become valid.
REQ-013 div_zero  output  1  B was 0 for the latched operation.
REQ-014 ovf  output  1  quotient not representable (A=-32768, B=-1).

Function
REQ-015 FSM states: IDLE, CALC, FIN; IDLE after reset.
REQ-016 start rising edge (start=1 now, 0 at previous edge) in IDLE: latch |A|, |B|, sign bits; busy=1 from that edge.
REQ-017 start held high SHALL NOT retrigger; start edges while busy SHALL be ignored.
REQ-018 CALC: restoring shift-subtract, one quotient bit per cycle, 16 cycles, 5-bit counter from 16 down to 0.
REQ-019 Partial remainder SHALL be 9 bits unsigned so |B|=128 subtracts correctly.
REQ-020 After the 16th CALC cycle go to FIN; FIN applies signs, registers q, r, neg, ovf, pulses done, clears busy, returns to IDLE.
REQ-021 Latency: start edge sampled at edge k -> done=1 and results valid after edge k+17.
REQ-022 B=0: skip CALC, go IDLE->FIN; q=16'hFFFF, r=0, div_zero=1, neg=0; done after edge k+2.
REQ-023 A=-32768, B=-1: q=16'h7FFF saturated, r=0, ovf=1, neg=0, normal latency.
REQ-024 Outputs q, r, neg, div_zero, ovf SHALL hold until next accepted start; cleared at that start.
REQ-025 Sign application: q = -mag if signs differ; r = -rem if A<0; -0 yields 0.

Reset
REQ-026 rst=1 at any edge, including mid-CALC: state IDLE; q=0, r=0, neg=0, busy=0, done=0, div_zero=0, ovf=0, counter=0.
REQ-027 start high during or right after rst SHALL NOT start an operation until a new rising edge is seen; edge detector register resets to 1.

Structure
REQ-028 Shared package div_pkg SHALL hold state encoding typedef, N_DIVIDENDO/N_DIVISOR defaults, iteration count constant (16).
REQ-029 One sub-module magnitud (combinational two's-complement absolute value, parameterised width) instantiated for A and B.
REQ-030 Sign restore and saturation SHALL live in the top module FIN logic.

Verification (clk period 20 ns)
REQ-031 A=100, B=-7, start 0->1 -> after 17 edges q=16'hFFF2 (-14), r=8'h02, neg=1, done pulse 1 cycle.
REQ-032 A=-100, B=7 -> q=-14 (16'hFFF2), r=-2 (8'hFE), neg=1; A=-9, B=3 -> q=-3, r=0, neg=1.
REQ-033 A=5, B=0 -> done after 2 edges, q=16'hFFFF, r=0, div_zero=1, busy back to 0.
REQ-034 A=-32768, B=-1 -> q=16'h7FFF, ovf=1, r=0; A=-32768, B=-128 -> q=256, r=0, ovf=0.
REQ-035 start held high 300 ns -> exactly one done pulse; second edge during busy ignored.
REQ-036 rst pulsed 30 ns at CALC cycle 8 -> all outputs 0, IDLE; next start edge gives correct result for A=9, B=-3 (q=-3, r=0).
